// File: rtl/argmin_stream_pkg.sv
// rtl/argmin_stream_pkg.sv - shared width helpers for the argmin stream selector
package argmin_stream_pkg;

   // Ceiling log2; clog2(1) == 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Width of a disparity index; never narrower than one bit.
   function automatic int idx_bits(input int disp);
      return (clog2(disp) < 1) ? 1 : clog2(disp);
   endfunction

   // Width of the beat counter; never narrower than one bit.
   function automatic int cnt_bits(input int beats);
      return (clog2(beats) < 1) ? 1 : clog2(beats);
   endfunction

   // Width of a lane index inside one beat; never narrower than one bit.
   function automatic int lane_bits(input int lanes);
      return (clog2(lanes) < 1) ? 1 : clog2(lanes);
   endfunction

endpackage

// File: rtl/argmin_stream_lane_argmin.sv
// rtl/argmin_stream_lane_argmin.sv - combinational min/argmin over one beat of lanes
module lane_argmin
   import argmin_stream_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   localparam int LANE_BITS = lane_bits(LANES)
) (
   input  logic [LANES*WIDTH-1:0] words,
   output logic [WIDTH-1:0]       min_value,
   output logic [LANE_BITS-1:0]   min_lane
);

   // Tree is padded to a power of two; heap layout, root at node 0,
   // leaves at LEAVES-1 .. 2*LEAVES-2, children of n at 2n+1 / 2n+2.
   localparam int LEAVES = 1 << clog2(LANES);
   localparam int NODES  = 2 * LEAVES - 1;

   // Binary reduction; the left (lower-lane) child wins ties, so all-ones
   // pad leaves, which always sit to the right of real lanes, never win.
   always_comb begin : p_tree
      automatic logic [LEAVES*WIDTH-1:0] padded;
      automatic logic [WIDTH-1:0]        node_val [NODES];
      automatic logic [LANE_BITS-1:0]    node_idx [NODES];

      padded = '1;
      padded[LANES*WIDTH-1:0] = words;

      for (int i = 0; i < LEAVES; i++) begin
         node_val[LEAVES-1+i] = padded[WIDTH*i +: WIDTH];
         node_idx[LEAVES-1+i] = LANE_BITS'(i);
      end

      for (int n = LEAVES - 2; n >= 0; n--) begin
         if (node_val[2*n+2] < node_val[2*n+1]) begin
            node_val[n] = node_val[2*n+2];
            node_idx[n] = node_idx[2*n+2];
         end else begin
            node_val[n] = node_val[2*n+1];
            node_idx[n] = node_idx[2*n+1];
         end
      end

      min_value = node_val[0];
      min_lane  = node_idx[0];
   end

endmodule

// File: rtl/argmin_stream.sv
// rtl/argmin_stream.sv - streaming multi-beat winner-takes-all cost selector
module argmin_stream
   import argmin_stream_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int BEATS = 3,
   localparam int DISP     = LANES * BEATS,
   localparam int IDX_BITS = idx_bits(DISP),
   localparam int CNT_BITS = cnt_bits(BEATS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_words,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_min_value,
   output logic [IDX_BITS-1:0]    out_min_index
);

   localparam int                 LANE_BITS = lane_bits(LANES);
   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

   logic [CNT_BITS-1:0]  beat_cnt_q, beat_cnt_d;
   logic [WIDTH-1:0]     run_val_q, run_val_d;
   logic [IDX_BITS-1:0]  run_idx_q, run_idx_d;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_val_q, out_val_d;
   logic [IDX_BITS-1:0]  out_idx_q, out_idx_d;

   logic [WIDTH-1:0]     beat_min;
   logic [LANE_BITS-1:0] beat_lane;
   logic [IDX_BITS-1:0]  beat_idx;
   logic                 is_first, is_last, accept, take_beat;
   logic [WIDTH-1:0]     sel_val;
   logic [IDX_BITS-1:0]  sel_idx;

   lane_argmin #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_lane_argmin (
      .words     (in_words),
      .min_value (beat_min),
      .min_lane  (beat_lane)
   );

   // Handshake, running comparison and next-state for counter, running min and result.
   always_comb begin
      is_first  = (beat_cnt_q == '0);
      is_last   = (beat_cnt_q == LAST_BEAT);
      in_ready  = !is_last || !out_valid_q || out_ready;
      accept    = in_valid && in_ready;
      beat_idx  = IDX_BITS'(int'(beat_cnt_q) * LANES + int'(beat_lane));

      // Strict compare keeps the earlier (lower-index) beat on ties.
      take_beat = is_first || (beat_min < run_val_q);
      sel_val   = take_beat ? beat_min : run_val_q;
      sel_idx   = take_beat ? beat_idx : run_idx_q;

      beat_cnt_d  = beat_cnt_q;
      run_val_d   = run_val_q;
      run_idx_d   = run_idx_q;
      out_valid_d = out_valid_q;
      out_val_d   = out_val_q;
      out_idx_d   = out_idx_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
         run_val_d = sel_val;
         run_idx_d = sel_idx;
         if (is_last) begin
            beat_cnt_d  = '0;
            out_val_d   = sel_val;
            out_idx_d   = sel_idx;
            out_valid_d = 1'b1;
         end else begin
            beat_cnt_d  = beat_cnt_q + CNT_BITS'(1);
         end
      end
   end

   // State registers; reset discards any partially accumulated pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         run_val_q   <= '0;
         run_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_val_q   <= '0;
         out_idx_q   <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         run_val_q   <= run_val_d;
         run_idx_q   <= run_idx_d;
         out_valid_q <= out_valid_d;
         out_val_q   <= out_val_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_min_value = out_val_q;
   assign out_min_index = out_idx_q;

endmodule
